// File: rtl/data_memory_pipelined.sv
// data_memory_pipelined: latency-configurable byte-addressable RV32 data memory with request/response handshake
module data_memory_pipelined #(
    parameter int DEPTH_BYTES = 2048,
    parameter int LATENCY     = 2
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iReqValid,
    output logic        oReady,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic [2:0]  iFunct3,
    input  logic [31:0] iAddress,
    input  logic [31:0] iWriteData,
    output logic        oRespValid,
    output logic [31:0] oReadData,
    output logic        oError,
    output logic [1:0]  oErrCode
);
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    logic [1:0]    state;
    logic [2:0]    cnt;
    logic [31:0]   addrQ;
    logic [31:0]   dataQ;
    logic [2:0]    funct3Q;
    logic          readQ;
    logic          writeQ;
    logic [7:0]    mem [DEPTH_BYTES];

    logic          accept;
    logic          enterResp;
    logic [31:0]   eAddr;
    logic [31:0]   eData;
    logic [2:0]    eFunct3;
    logic          eRead;
    logic          eWrite;
    logic [2:0]    size;
    logic [32:0]   endAddr;
    logic          illegal;
    logic          outOfRange;
    logic          misaligned;
    logic [1:0]    errCode;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [AW-1:0] a3;
    logic [7:0]    b0;
    logic [7:0]    b1;
    logic [7:0]    b2;
    logic [7:0]    b3;
    logic [31:0]   loadData;
    logic [31:0]   respData;

    assign oReady    = state != WAIT;
    assign accept    = iReqValid && oReady && !iRst;
    // With single-cycle latency the access completes on the accepting edge, so it must use the live inputs.
    assign enterResp = (LATENCY == 1) ? accept : (state == WAIT && cnt == 3'd0);
    assign eAddr     = (LATENCY == 1) ? iAddress : addrQ;
    assign eData     = (LATENCY == 1) ? iWriteData : dataQ;
    assign eFunct3   = (LATENCY == 1) ? iFunct3 : funct3Q;
    assign eRead     = (LATENCY == 1) ? iMemRead : readQ;
    assign eWrite    = (LATENCY == 1) ? iMemWrite : writeQ;

    assign size       = (eFunct3[1:0] == 2'b00) ? 3'd1 : (eFunct3[1:0] == 2'b01) ? 3'd2 : 3'd4;
    assign endAddr    = {1'b0, eAddr} + {30'd0, size};
    assign illegal    = (eRead == eWrite) || (eFunct3[1:0] == 2'b11) || (eFunct3 == 3'b110) || (eWrite && eFunct3[2]);
    assign outOfRange = endAddr > 33'(DEPTH_BYTES);
    assign misaligned = (size == 3'd2 && eAddr[0]) || (size == 3'd4 && eAddr[1:0] != 2'b00);
    assign errCode    = illegal ? 2'b11 : outOfRange ? 2'b10 : misaligned ? 2'b01 : 2'b00;

    assign a0 = eAddr[AW-1:0];
    assign a1 = a0 + AW'(1);
    assign a2 = a0 + AW'(2);
    assign a3 = a0 + AW'(3);
    assign b0 = mem[a0];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    assign loadData = (eFunct3 == 3'b000) ? {{24{b0[7]}}, b0} :
                      (eFunct3 == 3'b001) ? {{16{b1[7]}}, b1, b0} :
                      (eFunct3 == 3'b100) ? {24'd0, b0} :
                      (eFunct3 == 3'b101) ? {16'd0, b1, b0} :
                      {b3, b2, b1, b0};
    assign respData = (errCode != 2'b00 || !eRead) ? 32'd0 : loadData;

    // Store commit: little-endian byte lanes, only for legal in-range stores.
    always_ff @(posedge iClk) begin
        if (enterResp && eWrite && errCode == 2'b00) begin
            mem[a0] <= eData[7:0];
            if (size != 3'd1) mem[a1] <= eData[15:8];
            if (size == 3'd4) begin
                mem[a2] <= eData[23:16];
                mem[a3] <= eData[31:24];
            end
        end
    end

    // Request capture at acceptance so later input changes cannot disturb an in-flight access.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            addrQ   <= 32'd0;
            dataQ   <= 32'd0;
            funct3Q <= 3'd0;
            readQ   <= 1'b0;
            writeQ  <= 1'b0;
        end else if (accept) begin
            addrQ   <= iAddress;
            dataQ   <= iWriteData;
            funct3Q <= iFunct3;
            readQ   <= iMemRead;
            writeQ  <= iMemWrite;
        end
    end

    // Control FSM: IDLE/RESP accept, WAIT counts down the remaining latency.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else if (state == WAIT) begin
            if (cnt == 3'd0) state <= RESP;
            else cnt <= cnt - 3'd1;
        end else if (accept) begin
            state <= (LATENCY == 1) ? RESP : WAIT;
            cnt   <= CNT_INIT;
        end else begin
            state <= IDLE;
        end
    end

    // Response registers; data and error fields hold until the next response.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oRespValid <= 1'b0;
            oReadData  <= 32'd0;
            oError     <= 1'b0;
            oErrCode   <= 2'b00;
        end else begin
            oRespValid <= enterResp;
            if (enterResp) begin
                oReadData <= respData;
                oError    <= errCode != 2'b00;
                oErrCode  <= errCode;
            end
        end
    end
endmodule

// File: tb/tb_data_memory_pipelined.sv
// tb_data_memory_pipelined: directed vector bench over LATENCY 1, 2 and 4 instances
module tb_data_memory_pipelined;
    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expData;
        logic        expErr;
        logic [1:0]  expCode;
    } vec_t;

    logic        clk;
    logic [2:0]  rstV;
    logic [2:0]  reqV;
    logic [2:0]  rdy;
    logic [2:0]  respV;
    logic [2:0]  errV;
    logic [31:0] rdata [3];
    logic [1:0]  code [3];
    logic        memRead;
    logic        memWrite;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] writeData;
    int          nChecks;
    int          nErrors;
    vec_t        vecs [25];
    vec_t        bb [8];

    data_memory_pipelined #(.DEPTH_BYTES(2048), .LATENCY(1)) dut1 (
        .iClk(clk), .iRst(rstV[0]), .iReqValid(reqV[0]), .oReady(rdy[0]),
        .iMemRead(memRead), .iMemWrite(memWrite), .iFunct3(funct3), .iAddress(address),
        .iWriteData(writeData), .oRespValid(respV[0]), .oReadData(rdata[0]),
        .oError(errV[0]), .oErrCode(code[0]));

    data_memory_pipelined #(.DEPTH_BYTES(2048), .LATENCY(2)) dut2 (
        .iClk(clk), .iRst(rstV[1]), .iReqValid(reqV[1]), .oReady(rdy[1]),
        .iMemRead(memRead), .iMemWrite(memWrite), .iFunct3(funct3), .iAddress(address),
        .iWriteData(writeData), .oRespValid(respV[1]), .oReadData(rdata[1]),
        .oError(errV[1]), .oErrCode(code[1]));

    data_memory_pipelined #(.DEPTH_BYTES(2048), .LATENCY(4)) dut4 (
        .iClk(clk), .iRst(rstV[2]), .iReqValid(reqV[2]), .oReady(rdy[2]),
        .iMemRead(memRead), .iMemWrite(memWrite), .iFunct3(funct3), .iAddress(address),
        .iWriteData(writeData), .oRespValid(respV[2]), .oReadData(rdata[2]),
        .oError(errV[2]), .oErrCode(code[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] expData, input logic expErr, input logic [1:0] expCode);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.expData = expData; v.expErr = expErr; v.expCode = expCode;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        memRead = v.rd; memWrite = v.wr; funct3 = v.f3; address = v.addr; writeData = v.wdata;
    endtask

    // One request on instance s, then wait (bounded) for its response and check one-shot strobe.
    task automatic doReq(input int s, input int lat, input vec_t v, input string tag);
        int k;
        logic got;
        @(negedge clk);
        chk({tag, " ready"}, 32'(rdy[s]), 32'd1);
        apply(v);
        reqV[s] = 1'b1;
        @(posedge clk);
        #1 reqV[s] = 1'b0;
        k = 0;
        got = 1'b0;
        while (k < 12 && !got) begin
            @(negedge clk);
            k++;
            if (respV[s]) got = 1'b1;
        end
        chk({tag, " latency"}, 32'(k), 32'(lat));
        chk({tag, " data"}, rdata[s], v.expData);
        chk({tag, " err"}, 32'(errV[s]), 32'(v.expErr));
        chk({tag, " code"}, 32'(code[s]), 32'(v.expCode));
        @(negedge clk);
        chk({tag, " single"}, 32'(respV[s]), 32'd0);
    endtask

    initial begin
        int cnt;
        nChecks = 0;
        nErrors = 0;
        rstV = 3'b000; reqV = 3'b000;
        memRead = 0; memWrite = 0; funct3 = 0; address = 0; writeData = 0;

        vecs[0]  = mk(0, 1, 3'b010, 32'h10,       32'hDEADBEEF, 32'h0,        0, 2'b00);
        vecs[1]  = mk(1, 0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 0, 2'b00);
        vecs[2]  = mk(1, 0, 3'b000, 32'h13,       32'h0,        32'hFFFFFFDE, 0, 2'b00);
        vecs[3]  = mk(1, 0, 3'b100, 32'h13,       32'h0,        32'h000000DE, 0, 2'b00);
        vecs[4]  = mk(1, 0, 3'b001, 32'h12,       32'h0,        32'hFFFFDEAD, 0, 2'b00);
        vecs[5]  = mk(1, 0, 3'b101, 32'h10,       32'h0,        32'h0000BEEF, 0, 2'b00);
        vecs[6]  = mk(0, 1, 3'b000, 32'h11,       32'h55,       32'h0,        0, 2'b00);
        vecs[7]  = mk(1, 0, 3'b010, 32'h10,       32'h0,        32'hDEAD55EF, 0, 2'b00);
        vecs[8]  = mk(1, 0, 3'b010, 32'h12,       32'h0,        32'h0,        1, 2'b01);
        vecs[9]  = mk(0, 1, 3'b001, 32'h7FE,      32'hAAAA,     32'h0,        0, 2'b00);
        vecs[10] = mk(0, 1, 3'b010, 32'h7FE,      32'h12345678, 32'h0,        1, 2'b10);
        vecs[11] = mk(1, 0, 3'b101, 32'h7FE,      32'h0,        32'h0000AAAA, 0, 2'b00);
        vecs[12] = mk(1, 0, 3'b011, 32'h0,        32'h0,        32'h0,        1, 2'b11);
        vecs[13] = mk(1, 1, 3'b010, 32'h10,       32'h0,        32'h0,        1, 2'b11);
        vecs[14] = mk(0, 0, 3'b010, 32'h10,       32'h0,        32'h0,        1, 2'b11);
        vecs[15] = mk(0, 1, 3'b100, 32'h10,       32'h0,        32'h0,        1, 2'b11);
        vecs[16] = mk(1, 0, 3'b010, 32'h10,       32'h0,        32'hDEAD55EF, 0, 2'b00);
        vecs[17] = mk(1, 0, 3'b001, 32'h11,       32'h0,        32'h0,        1, 2'b01);
        vecs[18] = mk(1, 0, 3'b000, 32'h800,      32'h0,        32'h0,        1, 2'b10);
        vecs[19] = mk(1, 0, 3'b001, 32'hFFFFFFFF, 32'h0,        32'h0,        1, 2'b10);
        vecs[20] = mk(0, 1, 3'b010, 32'h7FC,      32'h81020304, 32'h0,        0, 2'b00);
        vecs[21] = mk(1, 0, 3'b000, 32'h7FF,      32'h0,        32'hFFFFFF81, 0, 2'b00);
        vecs[22] = mk(1, 0, 3'b010, 32'h7FC,      32'h0,        32'h81020304, 0, 2'b00);
        vecs[23] = mk(1, 0, 3'b101, 32'h7FE,      32'h0,        32'h00008102, 0, 2'b00);
        vecs[24] = mk(1, 0, 3'b000, 32'h10,       32'h0,        32'hFFFFFFEF, 0, 2'b00);

        bb[0] = mk(0, 1, 3'b010, 32'h0, 32'h11111111, 32'h0,        0, 2'b00);
        bb[1] = mk(0, 1, 3'b010, 32'h4, 32'h22222222, 32'h0,        0, 2'b00);
        bb[2] = mk(1, 0, 3'b010, 32'h0, 32'h0,        32'h11111111, 0, 2'b00);
        bb[3] = mk(1, 0, 3'b010, 32'h4, 32'h0,        32'h22222222, 0, 2'b00);
        bb[4] = mk(0, 1, 3'b000, 32'h4, 32'h80,       32'h0,        0, 2'b00);
        bb[5] = mk(1, 0, 3'b000, 32'h4, 32'h0,        32'hFFFFFF80, 0, 2'b00);
        bb[6] = mk(1, 0, 3'b101, 32'h4, 32'h0,        32'h00002280, 0, 2'b00);
        bb[7] = mk(1, 0, 3'b010, 32'h0, 32'h0,        32'h11111111, 0, 2'b00);

        #1 rstV = 3'b111;
        #2;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("reset%0d ready", s), 32'(rdy[s]), 32'd1);
            chk($sformatf("reset%0d resp", s), 32'(respV[s]), 32'd0);
            chk($sformatf("reset%0d data", s), rdata[s], 32'd0);
            chk($sformatf("reset%0d err", s), 32'(errV[s]), 32'd0);
            chk($sformatf("reset%0d code", s), 32'(code[s]), 32'd0);
        end
        repeat (2) @(negedge clk);
        rstV = 3'b000;

        for (int i = 0; i < 25; i++) doReq(1, 2, vecs[i], $sformatf("v%0d", i));

        // Load held during a store's WAIT is accepted only in RESP and sees the new data.
        @(negedge clk);
        apply(mk(0, 1, 3'b010, 32'h40, 32'hCAFEF00D, 0, 0, 0));
        reqV[1] = 1'b1;
        @(posedge clk);
        #1 apply(mk(1, 0, 3'b010, 32'h40, 32'h0, 0, 0, 0));
        @(negedge clk);
        chk("raw wait ready", 32'(rdy[1]), 32'd0);
        chk("raw wait resp", 32'(respV[1]), 32'd0);
        @(negedge clk);
        chk("raw store resp", 32'(respV[1]), 32'd1);
        chk("raw store data", rdata[1], 32'd0);
        chk("raw resp ready", 32'(rdy[1]), 32'd1);
        @(posedge clk);
        #1 reqV[1] = 1'b0;
        @(negedge clk);
        chk("raw load wait", 32'(respV[1]), 32'd0);
        chk("raw load busy", 32'(rdy[1]), 32'd0);
        @(negedge clk);
        chk("raw load resp", 32'(respV[1]), 32'd1);
        chk("raw load data", rdata[1], 32'hCAFEF00D);
        @(negedge clk);
        chk("raw single", 32'(respV[1]), 32'd0);

        // Address changes while busy must not affect the in-flight load.
        @(negedge clk);
        apply(mk(1, 0, 3'b010, 32'h10, 32'h0, 0, 0, 0));
        reqV[1] = 1'b1;
        @(posedge clk);
        #1 address = 32'h40;
        @(negedge clk);
        chk("hold busy", 32'(rdy[1]), 32'd0);
        @(negedge clk);
        chk("hold resp", 32'(respV[1]), 32'd1);
        chk("hold data", rdata[1], 32'hDEAD55EF);
        reqV[1] = 1'b0;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (respV[1]) cnt++;
        end
        chk("hold extra resp", 32'(cnt), 32'd0);

        // Back-to-back with single-cycle latency.
        @(negedge clk);
        apply(bb[0]);
        reqV[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (i + 1 < 8) apply(bb[i + 1]);
            else reqV[0] = 1'b0;
            @(negedge clk);
            chk($sformatf("bb%0d resp", i), 32'(respV[0]), 32'd1);
            chk($sformatf("bb%0d ready", i), 32'(rdy[0]), 32'd1);
            chk($sformatf("bb%0d data", i), rdata[0], bb[i].expData);
            chk($sformatf("bb%0d err", i), 32'(errV[0]), 32'd0);
        end
        @(negedge clk);
        chk("bb idle", 32'(respV[0]), 32'd0);

        // Reset during a LATENCY=4 store drops it.
        doReq(2, 4, mk(0, 1, 3'b010, 32'h20, 32'h0, 32'h0, 0, 2'b00), "l4 init");
        @(negedge clk);
        apply(mk(0, 1, 3'b010, 32'h20, 32'h12345678, 0, 0, 0));
        reqV[2] = 1'b1;
        @(posedge clk);
        #1 reqV[2] = 1'b0;
        @(negedge clk);
        chk("l4 busy", 32'(rdy[2]), 32'd0);
        @(negedge clk);
        rstV[2] = 1'b1;
        #1;
        chk("l4 rst ready", 32'(rdy[2]), 32'd1);
        chk("l4 rst resp", 32'(respV[2]), 32'd0);
        @(negedge clk);
        rstV[2] = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (respV[2]) cnt++;
        end
        chk("l4 dropped resp", 32'(cnt), 32'd0);
        doReq(2, 4, mk(1, 0, 3'b010, 32'h20, 32'h0, 32'h0, 0, 2'b00), "l4 reload");

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule

// File: doc/data_memory_pipelined.md
# data_memory_pipelined

Clocked, parametrised byte-addressable data memory for the RV32 load/store path. It replaces the combinational data memory with a request/response handshake, configurable depth and access latency, and full funct3 decoding of load and store widths. It also reports misaligned, out-of-range and illegal accesses instead of silently corrupting memory. It sits between the MEM stage and the data store, separate from instruction memory.

## Interface
- DEPTH_BYTES, 2048, memory size in bytes; power of two, ≥ 8
- LATENCY, 2, cycles from request acceptance to response; legal range 1–8
- iClk  in  1  clock, all state updates on rising edge
- iRst  in  1  reset, asynchronous, active-high
- iReqValid  in  1  request present
- oReady  out  1  block can accept a request this cycle
- iMemRead  in  1  request is a load
- iMemWrite  in  1  request is a store
- iFunct3  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- iAddress  in  32  byte address
- iWriteData  in  32  store data, little-endian, low bytes used for B/H
- oRespValid  out  1  one-cycle response strobe
- oReadData  out  32  load result (sign/zero-extended); 0 for stores and errors
- oError  out  1  valid with oRespValid; access rejected
- oErrCode  out  2  00 none, 01 misaligned, 10 out of range, 11 illegal op

## Operation
- FSM states: IDLE, WAIT, RESP. oReady = 1 in IDLE and RESP, 0 in WAIT.
- Accept when iReqValid && oReady at a rising edge. Latch address, data, funct3, read/write flags.
- After acceptance: if LATENCY == 1, go to RESP. Otherwise go to WAIT with counter = LATENCY-2, decrement each cycle, and go to RESP when the counter reaches 0.
- RESP lasts one cycle. If a new request is accepted in RESP, go to WAIT or RESP per the rule above. Otherwise go to IDLE.
- Error check happens at the edge entering RESP, with priority illegal > out of range > misaligned:
  - Illegal: iMemRead == iMemWrite (both or neither); store funct3 not in {000,001,010}; load funct3 in {011,110,111}.
  - Out of range: address + size > DEPTH_BYTES, where size is 1/2/4 and the sum is computed in 33 bits (no wrap).
  - Misaligned: H/HU with addr[0] ≠ 0; W with addr[1:0] ≠ 0.
- Erroring request: memory is not modified, oReadData = 0, oError = 1, oErrCode is set.
- Store commit: bytes written at the edge entering RESP. B writes [addr]; H writes [addr], [addr+1]; W writes [addr]..[addr+3]; little-endian.
- Load data is registered at the same edge. B/H are sign-extended from bit 7/15; BU/HU are zero-extended; W is taken as-is.
- oReadData is held until the next response; it is not cleared when leaving RESP.
- Memory contents are not reset; they are undefined until written.

## Timing
- Reset values: oReady = 1, oRespValid = 0, oReadData = 0, oError = 0, oErrCode = 00. FSM goes to IDLE.
- Latency: a request accepted at edge N produces oRespValid high for the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after acceptance.
- Throughput: one request per LATENCY cycles (back-to-back acceptance in RESP).
- Read-after-write: a load accepted in the RESP cycle of a store to the same address returns the new data.
- Reset mid-operation: a pending request is dropped, with no store commit and no response. oReady = 1 immediately (asynchronous).
- iReqValid while oReady = 0 is ignored. The requester must hold or re-present it.
- Request inputs are sampled only at acceptance; later changes have no effect on an in-flight access.

## Test plan
- LATENCY = 2: SW 0xDEADBEEF @0x10, then LW @0x10 → store resp oReadData = 0, oError = 0; load resp 0xDEADBEEF exactly 2 cycles after each acceptance.
- Widths: after that word, LB @0x13 → 0xFFFFFFDE; LBU @0x13 → 0x000000DE; LH @0x12 → 0xFFFFDEAD; LHU @0x10 → 0x0000BEEF; SB 0x55 @0x11, then LW @0x10 → 0xDEAD55EF.
- Errors: LW @0x12 → oErrCode 01, data 0. SW @DEPTH_BYTES-2 → 10, memory unchanged. funct3 011 load → 11. iMemRead = iMemWrite = 1 → 11.
- Back-to-back with LATENCY = 1: requests on consecutive cycles → oRespValid high every cycle, oReady never low, responses in order.
- Reset mid-op with LATENCY = 4: SW 0x12345678 @0x20, assert iRst two cycles later → no response; LW @0x20 after a prior known value of 0 returns 0.
- Handshake: hold iReqValid during WAIT with changing iAddress → ignored. Only one response per accepted request.
